// File: rtl/keypad_matrix_scanner_if.sv
// Keypad scanner bus: groups the matrix side (row sense, column drive) and the
// debounced key outputs handed to the game core.
//   row_in      matrix rows, active-low, asynchronous to the scanner clock
//   col_out     column drive, one-hot active-low
//   key_code    code of last accepted key (4*row + col)
//   key_valid   high while the accepted key is held
//   key_press   one-cycle pulse on an accepted press
//   key_release one-cycle pulse on an accepted release
// master = scanner side, slave = matrix / consumer side.
interface keypad_matrix_scanner_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_press;
    logic       key_release;

    modport master (
        input  row_in,
        output col_out, key_code, key_valid, key_press, key_release
    );

    modport slave (
        output row_in,
        input  col_out, key_code, key_valid, key_press, key_release
    );
endinterface

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
// Scans a 4x4 active-low key matrix one column per scan slot, debounces a single
// key at a time and reports it as a 4-bit code with press/hold/release qualifiers.
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  asynchronous, active-high
//   bus    keypad_matrix_scanner_if.master (row_in in; col_out, key_code,
//          key_valid, key_press, key_release out)
// Parameters:
//   SCAN_DIV        clk cycles per column slot (>= 2)
//   DEBOUNCE_SCANS  consecutive stable scan ticks to accept a press/release (>= 1)
module keypad_matrix_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    keypad_matrix_scanner_if.master bus
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // Registered state
    logic [3:0]       row_meta_reg;
    logic [3:0]       row_sync_reg;
    logic [DIV_W-1:0] div_reg;
    state_t           state_reg;
    logic [1:0]       col_reg;
    logic [1:0]       cand_reg;
    logic [CNT_W-1:0] count_reg;
    logic [3:0]       col_out_reg;
    logic [3:0]       key_code_reg;
    logic             key_valid_reg;
    logic             key_press_reg;
    logic             key_release_reg;

    // Next-state values
    state_t           state_next;
    logic [1:0]       col_next;
    logic [1:0]       cand_next;
    logic [CNT_W-1:0] count_next;
    logic [3:0]       col_out_next;
    logic [3:0]       key_code_next;
    logic             key_valid_next;
    logic             key_press_next;
    logic             key_release_next;

    // Decision strobes from the FSM to the output logic
    logic             do_press;
    logic             do_release;

    logic             tick;
    logic             any_low;
    logic [1:0]       low_idx;
    logic             cand_low;
    logic [CNT_W-1:0] count_inc;
    logic             count_done;

    // Two-flop synchroniser; idles at all-ones like the pulled-up rows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta_reg <= 4'hF;
            row_sync_reg <= 4'hF;
        end else begin
            row_meta_reg <= bus.row_in;
            row_sync_reg <= row_meta_reg;
        end
    end

    // Free-running slot divider; one scan tick per column slot.
    assign tick = (div_reg == DIV_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg <= '0;
        end else if (tick) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + DIV_W'(1);
        end
    end

    // Lowest-index low row wins when several rows of one column are pressed.
    always_comb begin
        low_idx = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_sync_reg[r]) begin
                low_idx = 2'(r);
            end
        end
    end

    assign any_low    = (row_sync_reg != 4'hF);
    assign cand_low   = ~row_sync_reg[cand_reg];
    assign count_inc  = count_reg + CNT_W'(1);
    assign count_done = (count_inc == CNT_W'(DEBOUNCE_SCANS));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= SCAN;
            col_reg         <= 2'd0;
            cand_reg        <= 2'd0;
            count_reg       <= '0;
            col_out_reg     <= 4'b1110;
            key_code_reg    <= 4'd0;
            key_valid_reg   <= 1'b0;
            key_press_reg   <= 1'b0;
            key_release_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            col_reg         <= col_next;
            cand_reg        <= cand_next;
            count_reg       <= count_next;
            col_out_reg     <= col_out_next;
            key_code_reg    <= key_code_next;
            key_valid_reg   <= key_valid_next;
            key_press_reg   <= key_press_next;
            key_release_reg <= key_release_next;
        end
    end

    // Next-state logic; nothing moves except on a scan tick.
    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        cand_next  = cand_reg;
        count_next = count_reg;
        do_press   = 1'b0;
        do_release = 1'b0;

        if (tick) begin
            case (state_reg)
                SCAN: begin
                    if (any_low) begin
                        cand_next = low_idx;
                        if (DEBOUNCE_SCANS == 1) begin
                            do_press   = 1'b1;
                            count_next = '0;
                            state_next = HELD;
                        end else begin
                            count_next = CNT_W'(1);
                            state_next = DEBOUNCE;
                        end
                    end else begin
                        col_next = col_reg + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (cand_low) begin
                        if (count_done) begin
                            do_press   = 1'b1;
                            count_next = '0;
                            state_next = HELD;
                        end else begin
                            count_next = count_inc;
                        end
                    end else begin
                        // Bounce: drop the candidate quietly and move on.
                        count_next = '0;
                        col_next   = col_reg + 2'd1;
                        state_next = SCAN;
                    end
                end
                HELD: begin
                    if (!cand_low) begin
                        if (count_done) begin
                            do_release = 1'b1;
                            count_next = '0;
                            col_next   = col_reg + 2'd1;
                            state_next = SCAN;
                        end else begin
                            count_next = count_inc;
                        end
                    end else begin
                        count_next = '0;
                    end
                end
                default: begin
                    count_next = '0;
                    state_next = SCAN;
                end
            endcase
        end
    end

    // Column drive decoded from the next column index so col_out is a clean register.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            assign col_out_next[gi] = (col_next != 2'(gi));
        end
    endgenerate

    // Output logic; the column is frozen while a key is accepted, so col_reg is its column.
    always_comb begin
        key_code_next    = key_code_reg;
        key_valid_next   = key_valid_reg;
        key_press_next   = do_press;
        key_release_next = do_release;
        if (do_press) begin
            key_code_next  = {cand_next, col_reg};
            key_valid_next = 1'b1;
        end else if (do_release) begin
            key_valid_next = 1'b0;
        end
    end

    assign bus.col_out     = col_out_reg;
    assign bus.key_code    = key_code_reg;
    assign bus.key_valid   = key_valid_reg;
    assign bus.key_press   = key_press_reg;
    assign bus.key_release = key_release_reg;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// n counts rising edges since reset release; outputs are sampled on falling edges.
module tb_keypad_matrix_scanner;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   n;
    int   press_cnt;
    int   release_cnt;

    keypad_matrix_scanner_if bus();

    keypad_matrix_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count high cycles of each pulse so a wide or missing pulse changes the total.
    always @(posedge clk) begin
        if (bus.key_press === 1'b1)   press_cnt <= press_cnt + 1;
        if (bus.key_release === 1'b1) release_cnt <= release_cnt + 1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic to(input int t);
        while (n < t) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] col, input logic [3:0] code,
                              input logic valid, input logic press, input logic rel);
        check({tag, ".col"},   {4'h0, bus.col_out},     {4'h0, col});
        check({tag, ".code"},  {4'h0, bus.key_code},    {4'h0, code});
        check({tag, ".valid"}, {7'h0, bus.key_valid},   {7'h0, valid});
        check({tag, ".press"}, {7'h0, bus.key_press},   {7'h0, press});
        check({tag, ".rel"},   {7'h0, bus.key_release}, {7'h0, rel});
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        n           = 0;
        press_cnt   = 0;
        release_cnt = 0;
        reset       = 1'b1;
        bus.row_in  = 4'b1111;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n     = 0;

        // 1: reset values and free scan
        check_outs("t1_reset", 4'b1110, 4'd0, 1'b0, 1'b0, 1'b0);
        to(3);  check("t1_col_n3",  {4'h0, bus.col_out}, 8'h0E);
        to(4);  check("t1_col_n4",  {4'h0, bus.col_out}, 8'h0D);
        to(8);  check("t1_col_n8",  {4'h0, bus.col_out}, 8'h0B);
        to(12); check("t1_col_n12", {4'h0, bus.col_out}, 8'h07);
        to(16); check("t1_col_n16", {4'h0, bus.col_out}, 8'h0E);

        // 2: row 2 pressed in column 1 -> code 9
        to(20);
        check("t2_col_start", {4'h0, bus.col_out}, 8'h0D);
        bus.row_in = 4'b1011;
        to(28); check("t2_frozen", {4'h0, bus.col_out}, 8'h0D);
        to(31); check_outs("t2_pre", 4'b1101, 4'd0, 1'b0, 1'b0, 1'b0);
        to(32); check_outs("t2_press", 4'b1101, 4'd9, 1'b1, 1'b1, 1'b0);
        to(33); check_outs("t2_after", 4'b1101, 4'd9, 1'b1, 1'b0, 1'b0);

        // 3: release
        bus.row_in = 4'b1111;
        to(43); check_outs("t3_pre", 4'b1101, 4'd9, 1'b1, 1'b0, 1'b0);
        to(44); check_outs("t3_rel", 4'b1011, 4'd9, 1'b0, 1'b0, 1'b1);
        to(45); check_outs("t3_after", 4'b1011, 4'd9, 1'b0, 1'b0, 1'b0);

        // 4: one-tick bounce on row 0 in column 3
        to(48);
        check("t4_col3", {4'h0, bus.col_out}, 8'h07);
        bus.row_in = 4'b1110;
        to(52);
        bus.row_in = 4'b1111;
        to(53); check_outs("t4_deb", 4'b0111, 4'd9, 1'b0, 1'b0, 1'b0);
        to(56); check_outs("t4_resume", 4'b1110, 4'd9, 1'b0, 1'b0, 1'b0);
        to(57); check("t4_press_cnt", 8'(press_cnt), 8'd1);

        // 5: rows 1 and 3 in column 0 -> lowest row wins, code 4
        to(56 + 1);
        bus.row_in = 4'b0101;
        to(67); check("t5_pre_press", {7'h0, bus.key_press}, 8'h00);
        to(68); check_outs("t5_press", 4'b1110, 4'd4, 1'b1, 1'b1, 1'b0);
        to(70);
        bus.row_in = 4'b0100;    // extra key in row 0 while row 1 is held
        to(81);
        check_outs("t5_ignored", 4'b1110, 4'd4, 1'b1, 1'b0, 1'b0);
        check("t5_press_cnt", 8'(press_cnt), 8'd2);
        check("t5_rel_cnt", 8'(release_cnt), 8'd1);
        bus.row_in = 4'b1111;
        to(92); check_outs("t5_rel", 4'b1101, 4'd4, 1'b0, 1'b0, 1'b1);

        // 6: reset while debouncing (count=2)
        bus.row_in = 4'b1110;
        to(94); check("t6_rel_cnt", 8'(release_cnt), 8'd2);
        to(100); check("t6_frozen", {4'h0, bus.col_out}, 8'h0D);
        to(101);
        reset = 1'b1;
        #1;
        check_outs("t6_in_reset", 4'b1110, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n     = 0;
        to(8);  check("t6_col_hold", {4'h0, bus.col_out}, 8'h0E);
        to(11);
        check_outs("t6_pre", 4'b1110, 4'd0, 1'b0, 1'b0, 1'b0);
        check("t6_press_cnt", 8'(press_cnt), 8'd2);
        check("t6_rel_cnt2", 8'(release_cnt), 8'd2);
        to(12); check_outs("t6_press", 4'b1110, 4'd0, 1'b1, 1'b1, 1'b0);
        to(13); check("t6_press_w", {7'h0, bus.key_press}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
